// File: rtl/signed_seq_mul.sv
// Multi-cycle two's-complement signed multiplier using radix-2 Booth recoding.
// One multiplier bit retires per clock; start/busy/done handshake.
module signed_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] q;
  logic [WIDTH:0]   acc;
  logic             q_m1;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   sum;
  logic             last;

  // One guard bit on the accumulator keeps (-2^(W-1))^2 exact.
  always_comb begin
    a_ext = {mcand[WIDTH-1], mcand};
    sum   = acc;
    case ({q[0], q_m1})
      2'b01:   sum = acc + a_ext;
      2'b10:   sum = acc - a_ext;
      default: sum = acc;
    endcase
  end

  assign last = (count == CW'(WIDTH - 1));
  assign busy = (state == RUN);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      q       <= '0;
      acc     <= '0;
      q_m1    <= 1'b0;
      count   <= '0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= a;
            q     <= b;
            acc   <= '0;
            q_m1  <= 1'b0;
            count <= '0;
          end
        end
        RUN: begin
          // Arithmetic right shift of {sum, q, q_m1} by one.
          acc   <= {sum[WIDTH], sum[WIDTH:1]};
          q     <= {sum[0], q[WIDTH-1:1]};
          q_m1  <= q[0];
          count <= count + 1'b1;
          if (last) begin
            // Low 2*WIDTH bits of the shifted {acc, q}.
            product <= {sum, q[WIDTH-1:1]};
            done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_seq_mul.sv
// Directed and randomized self-checking bench for signed_seq_mul (WIDTH=8).
module tb_signed_seq_mul;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int checks = 0;
  int errors = 0;

  signed_seq_mul #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launches one operation and observes it on falling edges. lat counts the
  // falling edges after the start edge up to the one where done is seen
  // (WIDTH+1 for a WIDTH-edge latency); lat=0 means done never came.
  task automatic run_op(input logic signed [W-1:0] ia, input logic signed [W-1:0] ib,
                        output logic [2*W-1:0] prod, output int lat,
                        output int busy_n, output bit single);
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    lat = 0; busy_n = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        lat = n;
        break;
      end
    end
    prod = product;
    @(negedge clk);
    single = !done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b product=%h, want 0 0 0000", busy, done, product);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    logic [2*W-1:0] p; int lat, bn; bit s;
    run_op(-8'sd12, 8'sd3, p, lat, bn, s);
    checks++;
    if (p !== 16'hFFDC) begin
      errors++; $display("FAIL basic_product: got %h want FFDC", p);
    end
    checks++;
    if (lat !== W + 1 || bn !== W) begin
      errors++; $display("FAIL basic_timing: lat=%0d busy=%0d want %0d %0d", lat, bn, W + 1, W);
    end
    checks++;
    if (!s) begin
      errors++; $display("FAIL basic_done_width: done high 2 cycles, want 1");
    end
  endtask

  task automatic test_extremes();
    logic signed [W-1:0] va [4] = '{-8'sd128, 8'sd127, -8'sd1, 8'sd0};
    logic signed [W-1:0] vb [4] = '{-8'sd128, -8'sd128, -8'sd1, -8'sd77};
    logic [2*W-1:0]      ve [4] = '{16'h4000, 16'hC080, 16'h0001, 16'h0000};
    logic [2*W-1:0] p; int lat, bn; bit s;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], p, lat, bn, s);
      checks++;
      if (p !== ve[i] || lat !== W + 1) begin
        errors++;
        $display("FAIL extreme_%0d: product=%h lat=%0d want %h lat=%0d", i, p, lat, ve[i], W + 1);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int dones = 0; int first = 0;
    @(negedge clk);
    a = 8'sd7; b = -8'sd9; start = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 3) begin a = 8'sd3; b = 8'sd3; start = 1'b1; end
      if (n == 4) start = 1'b0;
      if (done) begin
        dones++;
        if (first == 0) begin
          first = n;
          checks++;
          if (product !== 16'hFFC1) begin
            errors++; $display("FAIL busy_start_product: got %h want FFC1", product);
          end
        end
      end
    end
    checks++;
    if (dones !== 1 || first !== W + 1) begin
      errors++; $display("FAIL busy_start_done: count=%0d at=%0d want 1 at %0d", dones, first, W + 1);
    end
  endtask

  task automatic test_back_to_back();
    int lat = 0;
    @(negedge clk);
    a = -8'sd12; b = 8'sd3; start = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (done) break;
    end
    checks++;
    if (done !== 1'b1 || product !== 16'hFFDC) begin
      errors++; $display("FAIL b2b_first: done=%b product=%h want 1 FFDC", done, product);
    end
    a = 8'sd5; b = -8'sd6;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || product !== 16'hFFDC) begin
          errors++;
          $display("FAIL b2b_hold: done=%b busy=%b product=%h want 0 1 FFDC", done, busy, product);
        end
      end
      if (done) begin lat = n; break; end
    end
    checks++;
    if (lat !== W + 1 || product !== 16'hFFE2) begin
      errors++; $display("FAIL b2b_second: lat=%0d product=%h want %0d FFE2", lat, product, W + 1);
    end
  endtask

  task automatic test_mid_reset();
    int dones = 0;
    logic [2*W-1:0] p; int lat, bn; bit s;
    @(negedge clk);
    a = 8'sd100; b = 8'sd100; start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b product=%h want 0 0 0000", busy, done, product);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++; $display("FAIL mid_reset_quiet: %0d active cycles, want 0", dones);
    end
    run_op(8'sd25, -8'sd4, p, lat, bn, s);
    checks++;
    if (p !== 16'hFF9C || lat !== W + 1) begin
      errors++; $display("FAIL mid_reset_next: product=%h lat=%0d want FF9C %0d", p, lat, W + 1);
    end
  endtask

  task automatic test_random();
    logic signed [W-1:0]   ra, rb;
    logic signed [2*W-1:0] exp_p;
    logic [2*W-1:0] p; int lat, bn; bit s;
    for (int i = 0; i < 2000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      exp_p = ra * rb;
      run_op(ra, rb, p, lat, bn, s);
      checks++;
      if (p !== exp_p || lat !== W + 1 || bn !== W || !s) begin
        errors++;
        $display("FAIL random: %0d*%0d product=%h lat=%0d busy=%0d single=%b want %h %0d %0d 1",
                 ra, rb, p, lat, bn, s, exp_p, W + 1, W);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_start_while_busy();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
